// File: rtl/lbp_pin_pkg.sv
// Shared widths and channel state type for the LBP pin sequencer.
// No ports; imported by lbp_qtr_serializer and lbp_pin_sequencer.
package lbp_pin_pkg;

    localparam int unsigned ADDR_W = 14;  // core address width
    localparam int unsigned DATA_W = 8;   // pixel width
    localparam int unsigned AQ_W   = 4;   // address pins per quarter
    localparam int unsigned DQ_W   = 2;   // LBP data pins per quarter
    localparam int unsigned NQTR   = 4;   // quarters per transaction

    typedef enum logic {
        IDLE,
        SEND
    } chan_state_e;

endpackage

// File: rtl/lbp_qtr_serializer.sv
// One pin channel: accepts a transaction when free, then drives its address
// (and optionally data) quarters MSB first on registered pins for four cycles,
// followed by a one-cycle strobe.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            request (already qualified by the caller)
//   addr_i, data_i   transaction payload, sampled when ack_o=1
//   ack_o            combinational accept
//   addr_qtr_o       address quarter pins
//   data_qtr_o       data quarter pins (0 when DataEn=0)
//   strobe_o         one-cycle strobe in the cycle after q3
//   idle_o           channel FSM is in IDLE
module lbp_qtr_serializer
    import lbp_pin_pkg::*;
#(
    parameter bit DataEn = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic [AQ_W-1:0]   addr_qtr_o,
    output logic [DQ_W-1:0]   data_qtr_o,
    output logic              strobe_o,
    output logic              idle_o
);

    localparam int unsigned ASH_W = (NQTR - 1) * AQ_W;  // address bits after q0
    localparam int unsigned DSH_W = DATA_W - DQ_W;      // data bits after d0
    localparam logic [1:0]  LastCnt = 2'(NQTR - 1);

    chan_state_e       state_q;
    logic [1:0]        cnt_q;
    logic [ASH_W-1:0]  ash_q;
    logic [DSH_W-1:0]  dsh_q;
    logic [AQ_W-1:0]   aq_q;
    logic [DQ_W-1:0]   dq_q;
    logic              strobe_q;
    logic              free;

    // Free in IDLE, or on the last quarter so back-to-back transfers leave no gap.
    assign free  = (state_q == IDLE) || (cnt_q == LastCnt);
    assign ack_o = req_i && free;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ash_q    <= '0;
            dsh_q    <= '0;
            aq_q     <= '0;
            dq_q     <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= (state_q == SEND) && (cnt_q == LastCnt);
            if (ack_o) begin
                state_q <= SEND;
                cnt_q   <= '0;
                aq_q    <= AQ_W'(addr_i[ADDR_W-1:ASH_W]);
                ash_q   <= addr_i[ASH_W-1:0];
                dq_q    <= data_i[DATA_W-1:DSH_W];
                dsh_q   <= data_i[DSH_W-1:0];
            end else if (state_q == SEND) begin
                if (cnt_q == LastCnt) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    aq_q    <= '0;
                    dq_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                    aq_q  <= ash_q[ASH_W-1 -: AQ_W];
                    ash_q <= {ash_q[ASH_W-AQ_W-1:0], {AQ_W{1'b0}}};
                    dq_q  <= dsh_q[DSH_W-1 -: DQ_W];
                    dsh_q <= {dsh_q[DSH_W-DQ_W-1:0], {DQ_W{1'b0}}};
                end
            end
        end
    end

    assign addr_qtr_o = aq_q;
    assign data_qtr_o = DataEn ? dq_q : '0;
    assign strobe_o   = strobe_q;
    assign idle_o     = (state_q == IDLE);

endmodule

// File: rtl/lbp_pin_sequencer.sv
// Pin-mux controller between the LBP core and the pad ring. Serializes gray
// reads and LBP writes onto quarter-width pins on two independent channels,
// captures returned gray pixels, and raises a sticky finish once the core is
// done and the write channel has drained.
// Ports:
//   I_clk, I_reset                         clock, synchronous active-high reset
//   I_rd_req/I_rd_addr/O_rd_ack            core read request and accept
//   O_rd_data/O_rd_valid                   returned gray pixel
//   I_wr_req/I_wr_addr/I_wr_data/O_wr_ack  core write request and accept
//   I_core_done                            core finished issuing writes
//   O_gray_addr_qtr/O_gray_req             gray memory pins and strobe
//   I_gray_ready/I_gray_data               gray memory status and pixel
//   O_lbp_addr_qtr/O_lbp_data_qtr          LBP memory pins
//   O_lbp_valid                            LBP write strobe
//   O_finish                               sticky completion flag
module lbp_pin_sequencer
    import lbp_pin_pkg::*;
(
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_rd_req,
    input  logic [ADDR_W-1:0] I_rd_addr,
    output logic              O_rd_ack,
    output logic [DATA_W-1:0] O_rd_data,
    output logic              O_rd_valid,
    input  logic              I_wr_req,
    input  logic [ADDR_W-1:0] I_wr_addr,
    input  logic [DATA_W-1:0] I_wr_data,
    output logic              O_wr_ack,
    input  logic              I_core_done,
    output logic [AQ_W-1:0]   O_gray_addr_qtr,
    output logic              O_gray_req,
    input  logic              I_gray_ready,
    input  logic [DATA_W-1:0] I_gray_data,
    output logic [AQ_W-1:0]   O_lbp_addr_qtr,
    output logic              O_lbp_valid,
    output logic [DQ_W-1:0]   O_lbp_data_qtr,
    output logic              O_finish
);

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;
    logic              finish_q;
    logic              wr_idle;
    logic              rd_idle_unused;
    logic [DQ_W-1:0]   rd_dq_unused;

    // Gray ready only matters at accept; nothing is accepted after finish.
    lbp_qtr_serializer #(
        .DataEn (1'b0)
    ) u_rd_chan (
        .clk_i      (I_clk),
        .rst_i      (I_reset),
        .req_i      (I_rd_req && I_gray_ready && !finish_q),
        .addr_i     (I_rd_addr),
        .data_i     ('0),
        .ack_o      (O_rd_ack),
        .addr_qtr_o (O_gray_addr_qtr),
        .data_qtr_o (rd_dq_unused),
        .strobe_o   (O_gray_req),
        .idle_o     (rd_idle_unused)
    );

    lbp_qtr_serializer #(
        .DataEn (1'b1)
    ) u_wr_chan (
        .clk_i      (I_clk),
        .rst_i      (I_reset),
        .req_i      (I_wr_req && !finish_q),
        .addr_i     (I_wr_addr),
        .data_i     (I_wr_data),
        .ack_o      (O_wr_ack),
        .addr_qtr_o (O_lbp_addr_qtr),
        .data_qtr_o (O_lbp_data_qtr),
        .strobe_o   (O_lbp_valid),
        .idle_o     (wr_idle)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            // Pixel is on the pads during the strobe cycle.
            rd_valid_q <= O_gray_req;
            if (O_gray_req) begin
                rd_data_q <= I_gray_data;
            end
            done_q <= done_q || I_core_done;
            // IDLE with no accept in progress means no write is pending.
            if (done_q && wr_idle && !O_wr_ack) begin
                finish_q <= 1'b1;
            end
        end
    end

    assign O_rd_data  = rd_data_q;
    assign O_rd_valid = rd_valid_q;
    assign O_finish   = finish_q;

endmodule

// File: tb/tb_lbp_pin_sequencer.sv
module tb_lbp_pin_sequencer;

    logic        I_clk;
    logic        I_reset;
    logic        I_rd_req;
    logic [13:0] I_rd_addr;
    logic        O_rd_ack;
    logic [7:0]  O_rd_data;
    logic        O_rd_valid;
    logic        I_wr_req;
    logic [13:0] I_wr_addr;
    logic [7:0]  I_wr_data;
    logic        O_wr_ack;
    logic        I_core_done;
    logic [3:0]  O_gray_addr_qtr;
    logic        O_gray_req;
    logic        I_gray_ready;
    logic [7:0]  I_gray_data;
    logic [3:0]  O_lbp_addr_qtr;
    logic        O_lbp_valid;
    logic [1:0]  O_lbp_data_qtr;
    logic        O_finish;

    lbp_pin_sequencer dut (
        .I_clk           (I_clk),
        .I_reset         (I_reset),
        .I_rd_req        (I_rd_req),
        .I_rd_addr       (I_rd_addr),
        .O_rd_ack        (O_rd_ack),
        .O_rd_data       (O_rd_data),
        .O_rd_valid      (O_rd_valid),
        .I_wr_req        (I_wr_req),
        .I_wr_addr       (I_wr_addr),
        .I_wr_data       (I_wr_data),
        .O_wr_ack        (O_wr_ack),
        .I_core_done     (I_core_done),
        .O_gray_addr_qtr (O_gray_addr_qtr),
        .O_gray_req      (O_gray_req),
        .I_gray_ready    (I_gray_ready),
        .I_gray_data     (I_gray_data),
        .O_lbp_addr_qtr  (O_lbp_addr_qtr),
        .O_lbp_valid     (O_lbp_valid),
        .O_lbp_data_qtr  (O_lbp_data_qtr),
        .O_finish        (O_finish)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // External memories: gray image and LBP result, plus pin history for the
    // combiner that reassembles quarters at each strobe.
    logic [7:0] gray_mem [0:16383];
    logic [7:0] lbp_mem [int];
    logic [3:0] hist_ga [4];
    logic [3:0] hist_la [4];
    logic [1:0] hist_ld [4];

    // Transaction-level model: per-cycle expected pin schedule (mod 8 slots),
    // last-accept cycle per channel, and the expected LBP memory.
    logic [3:0] e_ga   [8];
    logic       e_greq [8];
    logic [3:0] e_la   [8];
    logic [1:0] e_ld   [8];
    logic       e_lval [8];
    logic [13:0] e_wa  [8];
    logic [7:0] e_wd   [8];
    logic       e_rval [8];
    logic [7:0] e_rdv  [8];
    logic [7:0] em_lbp [int];
    int         rd_last;
    int         wr_last;
    logic [7:0] rd_hold;
    bit         fin_m;
    bit         done_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            e_ga[i] = '0; e_greq[i] = 1'b0; e_la[i] = '0; e_ld[i] = '0;
            e_lval[i] = 1'b0; e_wa[i] = '0; e_wd[i] = '0; e_rval[i] = 1'b0;
            e_rdv[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            hist_ga[i] = '0; hist_la[i] = '0; hist_ld[i] = '0;
        end
        rd_last = -100;
        wr_last = -100;
        rd_hold = '0;
        fin_m   = 1'b0;
        done_m  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge I_clk); #1;
        I_reset = 1'b1; I_rd_req = 1'b0; I_wr_req = 1'b0; I_core_done = 1'b0;
        model_clear();
        cyc++;
    endtask

    task automatic step(input bit rr, input logic [13:0] ra, input bit wr,
                        input logic [13:0] wa, input logic [7:0] wd, input bit cd,
                        input bit rdy, output bit rack, output bit wack);
        int s;
        bit er, ew, widle;
        logic [13:0] ga, la;
        @(posedge I_clk); #1;
        I_reset = 1'b0;
        I_rd_req = rr; I_rd_addr = ra;
        I_wr_req = wr; I_wr_addr = wa; I_wr_data = wd;
        I_core_done = cd; I_gray_ready = rdy;
        ga = {hist_ga[0][1:0], hist_ga[1], hist_ga[2], hist_ga[3]};
        I_gray_data = O_gray_req ? gray_mem[ga] : 8'($urandom);
        @(negedge I_clk);
        s = cyc % 8;
        if (e_rval[s]) rd_hold = e_rdv[s];
        if (e_lval[s]) em_lbp[int'(e_wa[s])] = e_wd[s];
        check("gray_addr_qtr", O_gray_addr_qtr, e_ga[s]);
        check("gray_req", O_gray_req, e_greq[s]);
        check("lbp_addr_qtr", O_lbp_addr_qtr, e_la[s]);
        check("lbp_data_qtr", O_lbp_data_qtr, e_ld[s]);
        check("lbp_valid", O_lbp_valid, e_lval[s]);
        check("rd_valid", O_rd_valid, e_rval[s]);
        check("rd_data", O_rd_data, rd_hold);
        check("finish", O_finish, fin_m);
        er = rr && rdy && (cyc >= rd_last + 4) && !fin_m;
        ew = wr && (cyc >= wr_last + 4) && !fin_m;
        check("rd_ack", O_rd_ack, er);
        check("wr_ack", O_wr_ack, ew);
        if (O_lbp_valid) begin
            la = {hist_la[0][1:0], hist_la[1], hist_la[2], hist_la[3]};
            lbp_mem[int'(la)] = {hist_ld[0], hist_ld[1], hist_ld[2], hist_ld[3]};
        end
        e_ga[s] = '0; e_greq[s] = 1'b0; e_la[s] = '0; e_ld[s] = '0;
        e_lval[s] = 1'b0; e_rval[s] = 1'b0;
        widle = (cyc >= wr_last + 5);
        if (er) begin
            rd_last = cyc;
            for (int k = 0; k < 4; k++)
                e_ga[(cyc + 1 + k) % 8] = 4'((ra >> (12 - 4 * k)) & 14'hF);
            e_greq[(cyc + 5) % 8] = 1'b1;
            e_rval[(cyc + 6) % 8] = 1'b1;
            e_rdv[(cyc + 6) % 8]  = gray_mem[ra];
        end
        if (ew) begin
            wr_last = cyc;
            for (int k = 0; k < 4; k++) begin
                e_la[(cyc + 1 + k) % 8] = 4'((wa >> (12 - 4 * k)) & 14'hF);
                e_ld[(cyc + 1 + k) % 8] = 2'((wd >> (6 - 2 * k)) & 8'h3);
            end
            e_lval[(cyc + 5) % 8] = 1'b1;
            e_wa[(cyc + 5) % 8]   = wa;
            e_wd[(cyc + 5) % 8]   = wd;
        end
        fin_m  = fin_m || (done_m && widle && !ew);
        done_m = done_m || cd;
        for (int i = 0; i < 3; i++) begin
            hist_ga[i] = hist_ga[i + 1]; hist_la[i] = hist_la[i + 1]; hist_ld[i] = hist_ld[i + 1];
        end
        hist_ga[3] = O_gray_addr_qtr; hist_la[3] = O_lbp_addr_qtr; hist_ld[3] = O_lbp_data_qtr;
        rack = O_rd_ack;
        wack = O_wr_ack;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit rk, wk;
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 1, rk, wk);
    endtask

    initial begin
        bit rk, wk;
        int a;
        I_reset = 1'b1; I_rd_req = 1'b0; I_rd_addr = '0; I_wr_req = 1'b0;
        I_wr_addr = '0; I_wr_data = '0; I_core_done = 1'b0; I_gray_ready = 1'b0;
        I_gray_data = '0;
        for (int i = 0; i < 16384; i++) gray_mem[i] = 8'($urandom);
        gray_mem[14'h2A5C] = 8'h7E;
        do_reset();
        do_reset();
        idle(2);

        // Single read.
        step(1, 14'h2A5C, 0, '0, '0, 0, 1, rk, wk);
        idle(7);
        check("single_read_data", O_rd_data, 8'h7E);

        // Single write.
        step(0, '0, 1, 14'h3FFF, 8'hB4, 0, 1, rk, wk);
        idle(7);
        check("single_write_mem", lbp_mem.exists(16383) ? {1'b0, lbp_mem[16383]} : 9'h100, 9'h0B4);

        // Continuous reads with request held high.
        a = 0;
        for (int i = 0; i < 100 && a < 16; i++) begin
            step(1, 14'(a), 0, '0, '0, 0, 1, rk, wk);
            if (rk) a++;
        end
        check("cont_reads_acked", a, 16);
        idle(8);

        // Simultaneous read and write.
        step(1, 14'h1357, 1, 14'h2468, 8'h9C, 0, 1, rk, wk);
        idle(8);

        // Reset at cnt==2 of a write, then a normal write.
        step(0, '0, 1, 14'h1234, 8'h5A, 0, 1, rk, wk);
        idle(2);
        do_reset();
        idle(2);
        step(0, '0, 1, 14'h0ABC, 8'hC3, 0, 1, rk, wk);
        idle(7);
        check("aborted_write_absent", lbp_mem.exists(14'h1234), 0);
        check("post_reset_write", lbp_mem.exists(14'h0ABC) ? {1'b0, lbp_mem[14'h0ABC]} : 9'h100, 9'h0C3);

        // Randomized traffic on both channels.
        for (int i = 0; i < 500; i++) begin
            step(bit'($urandom % 2), 14'($urandom), bit'($urandom % 2), 14'($urandom),
                 8'($urandom), 0, ($urandom % 4) != 0, rk, wk);
        end
        idle(8);

        // Last write with core_done pulsed mid-transfer, then late requests.
        step(0, '0, 1, 14'h0F0F, 8'h3C, 0, 1, rk, wk);
        step(0, '0, 0, '0, '0, 1, 1, rk, wk);
        idle(6);
        for (int i = 0; i < 6; i++) step(1, 14'(i), 1, 14'(i), 8'(i), 0, 1, rk, wk);
        check("finish_sticky", O_finish, 1);

        foreach (em_lbp[k])
            check("lbp_mem", lbp_mem.exists(k) ? {1'b0, lbp_mem[k]} : 9'h100, {1'b0, em_lbp[k]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
